serial_bus_arbiter: RTL and testbench
=====================================

Name: serial_bus_arbiter

Overview:
- Two-master arbiter for the bit-serial slave bus (swdata/srdata/smode/mvalid/svalid).
- Grants the single slave port to one master at a time, round-robin on contention.
- Muxes the granted master's serial signals to the slave and routes the slave's responses back.
- Sits between the master interfaces and the slave/address-decode path; exposes the granted master ID for the decoder.

Parameters:
MAX_HOLD, 64, maximum cycles a master may hold the grant (used only with the optional feature)
CNT_WIDTH, 8, width of the hold counter; must satisfy 2^CNT_WIDTH > MAX_HOLD

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
m1_req  in  1  master 1 bus request
m1_grant  out  1  master 1 owns the bus
m1_wdata  in  1  master 1 serial write/address bit
m1_mode  in  1  master 1 mode: 1=write, 0=read
m1_mvalid  in  1  master 1 valid
m1_rdata  out  1  serial read bit to master 1
m1_svalid  out  1  slave valid to master 1
m2_req, m2_grant, m2_wdata, m2_mode, m2_mvalid, m2_rdata, m2_svalid  same widths and meanings, for master 2
s_wdata  out  1  serial data to slave
s_mode  out  1  mode to slave
s_mvalid  out  1  valid to slave
s_rdata  in  1  serial read bit from slave
s_svalid  in  1  valid from slave
msel  out  1  granted master: 0=m1, 1=m2; valid only when bus_busy=1
bus_busy  out  1  a grant is active
timeout  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (async, rst=1): state=IDLE, last=M2 (so M1 wins the first tie), hold counter=0. All outputs 0 immediately, including while rst is held.
- States:
  - IDLE: no grant.
  - G1: M1 owns the bus.
  - G2: M2 owns the bus.
- IDLE transitions, requests sampled on the rising edge:
  - Only m1_req=1 -> G1.
  - Only m2_req=1 -> G2.
  - Both -> the master that is not "last".
  - Neither -> stay in IDLE.
  - Grant is visible 1 cycle after req is first sampled high.
- G1 -> IDLE when m1_req=0 and m1_mvalid=0 on the same edge. G2 is symmetric.
  - Grant is held while req=1 or mvalid=1, so a master cannot release mid-frame.
- On entering G1/G2, "last" updates to that master.
- After a release, IDLE lasts at least 1 cycle: the earliest grant to another master is 2 cycles after the releasing edge. This turnaround is guaranteed.
- Registered outputs: grants, bus_busy, msel, timeout.
- Combinational routing from the registered state:
  - s_wdata/s_mode/s_mvalid = granted master's inputs; 0 in IDLE.
  - Granted master's rdata/svalid = s_rdata/s_svalid.
  - Non-granted master's rdata/svalid = 0.
- Inputs from the non-granted master are ignored completely.
- Request dropped before the grant arrives: no grant is issued if req=0 when sampled in IDLE.
- Simultaneous release by the owner and a new request from the other master on the same edge: go to IDLE first, then grant the other master on the next edge.
- Hold counter:
  - Cleared on entry to G1/G2.
  - Increments each cycle in G1/G2, saturating at 2^CNT_WIDTH-1.

Optional Feature:
Macro ARB_HOLD_TIMEOUT_EN.
- Defined:
  - When the hold counter reaches MAX_HOLD-1 in G1/G2, force the state to IDLE on the next edge regardless of req/mvalid.
  - Pulse timeout=1 for that one cycle.
  - Keep "last" = timed-out master, so the other master wins the next tie.
  - The timed-out master may be re-granted only if the other master is not requesting.
- Undefined:
  - No forced release.
  - timeout tied to 0.
  - Counter logic may be omitted.

Test Plan:
1. Reset, then m1_req=1 at cycle 2 -> m1_grant=1, bus_busy=1, msel=0 at cycle 3. m1 drives 12 address + 8 data bits with mode=1; s_wdata bit-exact with m1_wdata on every cycle; m2_rdata=0.
2. m1_req and m2_req both rise on the same edge after reset -> M1 granted. M1 drops req/mvalid -> IDLE 1 cycle, then m2_grant=1, msel=1, exactly 2 cycles after the release edge.
3. M2 holds the grant and m1_req=1 throughout -> m1_grant stays 0 and m1 inputs never reach s_*. M2 read: s_svalid/s_rdata pulses appear only on m2_svalid/m2_rdata.
4. Granted master sets req=0 while mvalid=1 -> grant held until mvalid=0, then released on the next edge.
5. rst pulsed mid-frame while in G1 -> m1_grant, s_mvalid, bus_busy drop to 0 asynchronously, before the next clock edge. After release, the first tie goes to M1.
6. With ARB_HOLD_TIMEOUT_EN and MAX_HOLD=16: M1 holds req continuously with m2_req=1 -> forced release after 16 cycles, timeout=1 for exactly 1 cycle, M2 granted 2 cycles later. Without the macro -> M1 holds indefinitely and timeout stays 0.

Source files
------------

// File: rtl/serial_bus_arbiter.sv
// Two-master round-robin arbiter for the bit-serial slave bus.
// Define ARB_HOLD_TIMEOUT_EN to force release after MAX_HOLD cycles of ownership.
module serial_bus_arbiter #(
  parameter int MAX_HOLD  = 64,
  parameter int CNT_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic m1_req,
  output logic m1_grant,
  input  logic m1_wdata,
  input  logic m1_mode,
  input  logic m1_mvalid,
  output logic m1_rdata,
  output logic m1_svalid,
  input  logic m2_req,
  output logic m2_grant,
  input  logic m2_wdata,
  input  logic m2_mode,
  input  logic m2_mvalid,
  output logic m2_rdata,
  output logic m2_svalid,
  output logic s_wdata,
  output logic s_mode,
  output logic s_mvalid,
  input  logic s_rdata,
  input  logic s_svalid,
  output logic msel,
  output logic bus_busy,
  output logic timeout
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] G1   = 2'd1;
  localparam logic [1:0] G2   = 2'd2;

  localparam logic LAST_M1 = 1'b0;
  localparam logic LAST_M2 = 1'b1;

  if ((2 ** CNT_WIDTH) <= MAX_HOLD) begin : g_bad_cnt_width
    $error("CNT_WIDTH too small for MAX_HOLD");
  end

  logic [1:0]           state;
  logic [1:0]           state_next;
  logic                 last;
  logic                 last_next;
  logic [CNT_WIDTH-1:0] hold_cnt;
  logic                 force_rel;

`ifdef ARB_HOLD_TIMEOUT_EN
  assign force_rel = ((state == G1) || (state == G2)) &&
                     (hold_cnt == CNT_WIDTH'(MAX_HOLD - 1));
`else
  assign force_rel = 1'b0;
`endif

  // On a tie the master that did not own the bus last wins; "last" survives a timeout.
  always_comb begin
    state_next = state;
    last_next  = last;
    case (state)
      IDLE: begin
        if (m1_req && (!m2_req || (last == LAST_M2))) begin
          state_next = G1;
          last_next  = LAST_M1;
        end else if (m2_req) begin
          state_next = G2;
          last_next  = LAST_M2;
        end else begin
          state_next = IDLE;
        end
      end
      G1: begin
        if (force_rel || (!m1_req && !m1_mvalid)) state_next = IDLE;
        else                                      state_next = G1;
      end
      G2: begin
        if (force_rel || (!m2_req && !m2_mvalid)) state_next = IDLE;
        else                                      state_next = G2;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last     <= LAST_M2;
      m1_grant <= 1'b0;
      m2_grant <= 1'b0;
      bus_busy <= 1'b0;
      msel     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_next;
      last     <= last_next;
      m1_grant <= (state_next == G1);
      m2_grant <= (state_next == G2);
      bus_busy <= (state_next != IDLE);
      msel     <= (state_next == G2);
      timeout  <= force_rel;
    end
  end

  // Cleared on every grant entry, saturates while the grant is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= {CNT_WIDTH{1'b0}};
    end else if ((state_next == IDLE) || (state_next != state)) begin
      hold_cnt <= {CNT_WIDTH{1'b0}};
    end else if (hold_cnt != {CNT_WIDTH{1'b1}}) begin
      hold_cnt <= hold_cnt + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    s_wdata   = 1'b0;
    s_mode    = 1'b0;
    s_mvalid  = 1'b0;
    m1_rdata  = 1'b0;
    m1_svalid = 1'b0;
    m2_rdata  = 1'b0;
    m2_svalid = 1'b0;
    case (state)
      G1: begin
        s_wdata   = m1_wdata;
        s_mode    = m1_mode;
        s_mvalid  = m1_mvalid;
        m1_rdata  = s_rdata;
        m1_svalid = s_svalid;
      end
      G2: begin
        s_wdata   = m2_wdata;
        s_mode    = m2_mode;
        s_mvalid  = m2_mvalid;
        m2_rdata  = s_rdata;
        m2_svalid = s_svalid;
      end
      default: begin
        s_wdata = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Scoreboard bench for serial_bus_arbiter: directed steps push expected outputs,
// a negedge monitor pops and compares. Built with or without ARB_HOLD_TIMEOUT_EN.
module tb_serial_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m1_req = 1'b0, m1_wdata = 1'b0, m1_mode = 1'b0, m1_mvalid = 1'b0;
  logic m2_req = 1'b0, m2_wdata = 1'b0, m2_mode = 1'b0, m2_mvalid = 1'b0;
  logic s_rdata = 1'b0, s_svalid = 1'b0;
  logic m1_grant, m1_rdata, m1_svalid, m2_grant, m2_rdata, m2_svalid;
  logic s_wdata, s_mode, s_mvalid, msel, bus_busy, timeout;

  serial_bus_arbiter #(.MAX_HOLD(16), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .m1_req(m1_req), .m1_grant(m1_grant), .m1_wdata(m1_wdata), .m1_mode(m1_mode),
    .m1_mvalid(m1_mvalid), .m1_rdata(m1_rdata), .m1_svalid(m1_svalid),
    .m2_req(m2_req), .m2_grant(m2_grant), .m2_wdata(m2_wdata), .m2_mode(m2_mode),
    .m2_mvalid(m2_mvalid), .m2_rdata(m2_rdata), .m2_svalid(m2_svalid),
    .s_wdata(s_wdata), .s_mode(s_mode), .s_mvalid(s_mvalid),
    .s_rdata(s_rdata), .s_svalid(s_svalid),
    .msel(msel), .bus_busy(bus_busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [11:0] v;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic done = 1'b0;

  // Output order: grant1 grant2 busy msel timeout s_wdata s_mode s_mvalid m1_rdata m1_svalid m2_rdata m2_svalid
  function automatic logic [11:0] expect_vec(input logic [3:0] m1, input logic [3:0] m2,
                                             input logic [1:0] s, input logic [1:0] own,
                                             input logic to);
    logic [2:0] sbus;
    logic [1:0] r1, r2;
    sbus = (own == 2'd1) ? m1[2:0] : (own == 2'd2) ? m2[2:0] : 3'b000;
    r1   = (own == 2'd1) ? s : 2'b00;
    r2   = (own == 2'd2) ? s : 2'b00;
    return {own == 2'd1, own == 2'd2, own != 2'd0, own == 2'd2, to, sbus, r1, r2};
  endfunction

  // m = {req, wdata, mode, mvalid}; s = {rdata, svalid}; own = expected owner this cycle
  task automatic step(input string nm, input logic [3:0] m1, input logic [3:0] m2,
                      input logic [1:0] s, input logic [1:0] own, input logic to);
    exp_t e;
    {m1_req, m1_wdata, m1_mode, m1_mvalid} = m1;
    {m2_req, m2_wdata, m2_mode, m2_mvalid} = m2;
    {s_rdata, s_svalid} = s;
    e.name = nm;
    e.v    = expect_vec(m1, m2, s, own, to);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string nm, input logic [3:0] m1);
    rst = 1'b1;
    step(nm, m1, 4'b0000, 2'b00, 2'd0, 1'b0);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [11:0] act;
      e   = q.pop_front();
      act = {m1_grant, m2_grant, bus_busy, msel, timeout, s_wdata, s_mode, s_mvalid,
             m1_rdata, m1_svalid, m2_rdata, m2_svalid};
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got %b expected %b", e.name, act, e.v);
      end
    end
  end

  initial begin
    logic [19:0] pat;
    logic [3:0]  m2_rd_pat;
    pat       = 20'b1011_0010_1110_0101_1001;
    m2_rd_pat = 4'b0110;

    @(posedge clk);
    #1;
    do_reset("reset", 4'b1111);

    // Test 1: single master write frame
    step("t1_req", 4'b1000, 4'b0000, 2'b00, 2'd0, 1'b0);
    for (int i = 0; i < 20; i++)
      step("t1_frame", {1'b1, pat[19-i], 1'b1, 1'b1}, 4'b0000, {pat[i], 1'b1}, 2'd1, 1'b0);
    step("t1_release", 4'b0000, 4'b0000, 2'b00, 2'd1, 1'b0);
    step("t1_idle", 4'b0000, 4'b0000, 2'b00, 2'd0, 1'b0);

    // Test 2: tie after reset goes to M1, then turnaround to M2
    do_reset("t2_reset", 4'b0000);
    step("t2_tie", 4'b1000, 4'b1000, 2'b00, 2'd0, 1'b0);
    step("t2_g1", 4'b1101, 4'b1000, 2'b00, 2'd1, 1'b0);
    step("t2_rel", 4'b0000, 4'b1000, 2'b00, 2'd1, 1'b0);
    step("t2_turn", 4'b0000, 4'b1000, 2'b00, 2'd0, 1'b0);
    step("t2_g2", 4'b0000, 4'b1000, 2'b00, 2'd2, 1'b0);

    // Test 3: M2 read while M1 keeps requesting
    for (int i = 0; i < 4; i++)
      step("t3_read", 4'b1111, {1'b1, m2_rd_pat[i], 1'b0, 1'b1}, {m2_rd_pat[3-i], i[0]}, 2'd2, 1'b0);

    // Test 4: req dropped mid-frame, grant held until mvalid falls; then M1 after IDLE
    step("t4_hold_a", 4'b1111, 4'b0101, 2'b11, 2'd2, 1'b0);
    step("t4_hold_b", 4'b1111, 4'b0001, 2'b10, 2'd2, 1'b0);
    step("t4_rel", 4'b1111, 4'b0000, 2'b01, 2'd2, 1'b0);
    step("t4_idle", 4'b1000, 4'b1000, 2'b00, 2'd0, 1'b0);
    step("t4_g1", 4'b1111, 4'b0000, 2'b11, 2'd1, 1'b0);

    // Test 5: async reset mid-frame, then tie goes to M1
    step("t5_frame", 4'b1111, 4'b0000, 2'b00, 2'd1, 1'b0);
    do_reset("t5_async_rst", 4'b1111);
    step("t5_tie", 4'b1000, 4'b1000, 2'b00, 2'd0, 1'b0);
    step("t5_g1", 4'b1000, 4'b1000, 2'b00, 2'd1, 1'b0);
    step("t5_rel", 4'b0000, 4'b0000, 2'b00, 2'd1, 1'b0);
    step("t5_idle", 4'b0000, 4'b0000, 2'b00, 2'd0, 1'b0);

    // Test 6: M1 holds with M2 waiting
    step("t6_req", 4'b1000, 4'b0000, 2'b00, 2'd0, 1'b0);
`ifdef ARB_HOLD_TIMEOUT_EN
    for (int i = 0; i < 16; i++)
      step("t6_hold", 4'b1000, 4'b1000, 2'b00, 2'd1, 1'b0);
    step("t6_timeout", 4'b1000, 4'b1000, 2'b00, 2'd0, 1'b1);
    step("t6_g2", 4'b1000, 4'b1000, 2'b00, 2'd2, 1'b0);
    step("t6_g2_b", 4'b1000, 4'b1000, 2'b00, 2'd2, 1'b0);
`else
    for (int i = 0; i < 40; i++)
      step("t6_hold", 4'b1000, 4'b1000, 2'b00, 2'd1, 1'b0);
    step("t6_rel", 4'b0000, 4'b1000, 2'b00, 2'd1, 1'b0);
    step("t6_idle", 4'b0000, 4'b1000, 2'b00, 2'd0, 1'b0);
    step("t6_g2", 4'b0000, 4'b1000, 2'b00, 2'd2, 1'b0);
`endif

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
